hack_rom_loader: RTL and testbench

Streaming program loader that writes Hack machine code into the instruction ROM that the Hack `Computer` fetches from, i.e. the writer side of the ROM read port. Accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words and writes them at incrementing ROM addresses. Holds the CPU in reset until a complete, checksum-verified image is loaded, then releases it. Replaces file-based ROM preloading for synthesised systems.

---
 rtl/hack_loader_pkg.sv | 18 +
 rtl/hack_xor_checksum.sv | 22 ++
 rtl/hack_rom_loader.sv | 141 ++++++++++++++
 tb/tb_hack_rom_loader.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_loader_pkg.sv
// Shared types and widths for the Hack ROM loader.
// Byte-stream framing states and the word/byte widths of the Hack machine.
package hack_loader_pkg;

    localparam int HACK_WORD_W = 16;
    localparam int BYTE_W      = 8;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CSUM,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/hack_xor_checksum.sv
// Running XOR over the data bytes of a loader frame.
// The length and checksum bytes are excluded by the caller through en.
module hack_xor_checksum
    import hack_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic [BYTE_W-1:0] in_byte,
    output logic [BYTE_W-1:0] csum
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            csum <= '0;
        end else if (en) begin
            csum <= csum ^ in_byte;
        end
    end

endmodule

// File: rtl/hack_rom_loader.sv
// Streams a length-prefixed, XOR-checked Hack program into instruction ROM,
// holding the CPU in reset until the whole image has been verified.
module hack_rom_loader
    import hack_loader_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BYTE_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   start,
    output logic                   rom_we,
    output logic [ADDR_W-1:0]      rom_addr,
    output logic [HACK_WORD_W-1:0] rom_data,
    output logic                   cpu_reset,
    output logic                   done,
    output logic                   error,
    output logic [ADDR_W:0]        words_loaded
);

    // Largest legal word count is the full ROM, so N needs ADDR_W+1 bits.
    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

    loader_state_t     state;
    logic [BYTE_W-1:0] len_hi_byte;
    logic [BYTE_W-1:0] hi_byte;
    logic [ADDR_W:0]   word_count;
    logic [ADDR_W-1:0] addr_cnt;
    logic [BYTE_W-1:0] csum;
    logic              xfer;
    logic              rearm;
    logic              csum_en;
    logic [31:0]       len_word;
    logic [ADDR_W:0]   words_next;

    assign xfer       = in_valid && in_ready;
    assign rearm      = start && (state == DONE || state == ERROR);
    assign csum_en    = xfer && (state == DATA_HI || state == DATA_LO);
    assign len_word   = {16'd0, len_hi_byte, in_data};
    assign words_next = words_loaded + (ADDR_W + 1)'(1);

    hack_xor_checksum u_csum (
        .clk     (clk),
        .reset   (reset),
        .clear   (rearm),
        .en      (csum_en),
        .in_byte (in_data),
        .csum    (csum)
    );

    // in_ready is registered alongside the state so it always reflects
    // whether the current state is a receive state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= LEN_HI;
            in_ready     <= 1'b1;
            rom_we       <= 1'b0;
            rom_addr     <= '0;
            rom_data     <= '0;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            addr_cnt     <= '0;
            word_count   <= '0;
            len_hi_byte  <= '0;
            hi_byte      <= '0;
        end else begin
            rom_we <= 1'b0;
            case (state)
                LEN_HI: begin
                    if (xfer) begin
                        len_hi_byte <= in_data;
                        state       <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        word_count <= len_word[ADDR_W:0];
                        if (len_word > CAPACITY) begin
                            state    <= ERROR;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                        end else if (len_word == 32'd0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (xfer) begin
                        hi_byte <= in_data;
                        state   <= DATA_LO;
                    end
                end
                DATA_LO: begin
                    if (xfer) begin
                        rom_we       <= 1'b1;
                        rom_addr     <= addr_cnt;
                        rom_data     <= {hi_byte, in_data};
                        addr_cnt     <= addr_cnt + ADDR_W'(1);
                        words_loaded <= words_next;
                        state        <= (words_next == word_count) ? CSUM : DATA_HI;
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        if (in_data == csum) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                DONE, ERROR: begin
                    if (start) begin
                        state        <= LEN_HI;
                        in_ready     <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        cpu_reset    <= 1'b1;
                        words_loaded <= '0;
                        addr_cnt     <= '0;
                    end
                end
                default: begin
                    state    <= LEN_HI;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Self-checking bench for hack_rom_loader: frames are built from word lists,
// expected ROM writes are queued up front and matched against observed writes.
module tb_hack_rom_loader;

    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              cpu_reset;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    int checks = 0;
    int errors = 0;
    int rd_idx = 0;

    logic [ADDR_W-1:0] obs_addr_q[$];
    logic [15:0]       obs_data_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [15:0]       exp_data_q[$];
    logic [15:0]       words_q[$];
    logic [7:0]        frame_q[$];

    always #5 clk = ~clk;

    hack_rom_loader #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .start        (start),
        .rom_we       (rom_we),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    // Record every ROM write strobe; tests compare these against exp queues.
    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            obs_addr_q.push_back(rom_addr);
            obs_data_q.push_back(rom_data);
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Offer one byte and hold it until a transfer edge, bounded by a cycle budget.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited   = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout in_ready=%b want 1 for byte %h", in_ready, b);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Build a frame from words_q and queue the writes it should produce.
    task automatic build_frame(input logic use_csum, input logic [7:0] csum_value);
        logic [15:0] n;
        logic [15:0] w;
        logic [7:0]  x;
        n = 16'(words_q.size());
        x = 8'h00;
        frame_q.delete();
        frame_q.push_back(n[15:8]);
        frame_q.push_back(n[7:0]);
        foreach (words_q[i]) begin
            w = words_q[i];
            frame_q.push_back(w[15:8]);
            frame_q.push_back(w[7:0]);
            x = x ^ w[15:8] ^ w[7:0];
            exp_addr_q.push_back(ADDR_W'(i));
            exp_data_q.push_back(w);
        end
        frame_q.push_back(use_csum ? csum_value : x);
    endtask

    task automatic send_frame(input int max_gap, input int pulse_at);
        foreach (frame_q[i]) begin
            if (i == pulse_at) pulse_start();
            if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
            send_byte(frame_q[i]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        idle(2);
        reset = 1'b0;
        start = 1'b0;
        checks++;
        if ({in_ready, rom_we, cpu_reset, done, error} !== 5'b10100) begin
            errors++;
            $display("[TB] FAIL reset_flags got ready/we/cpurst/done/err=%b want 10100",
                     {in_ready, rom_we, cpu_reset, done, error});
        end
        checks++;
        if (rom_addr !== '0 || rom_data !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_rom got addr=%0d data=%h want 0/0000", rom_addr, rom_data);
        end
        checks++;
        if (words_loaded !== '0) begin
            errors++;
            $display("[TB] FAIL reset_words got %0d want 0", words_loaded);
        end
    endtask

    task automatic test_basic();
        words_q = '{16'h0010, 16'hFC10};
        build_frame(1'b0, 8'h00);
        send_frame(0, -1);
        foreach (exp_addr_q[i]) begin
            checks++;
            if (rd_idx >= obs_addr_q.size()) begin
                errors++;
                $display("[TB] FAIL basic_write%0d got none want addr=%0d", i, exp_addr_q[i]);
            end else if (obs_addr_q[rd_idx] !== exp_addr_q[i] || obs_data_q[rd_idx] !== exp_data_q[i]) begin
                errors++;
                $display("[TB] FAIL basic_write%0d got %0d:%h want %0d:%h", i,
                         obs_addr_q[rd_idx], obs_data_q[rd_idx], exp_addr_q[i], exp_data_q[i]);
            end
            rd_idx++;
        end
        exp_addr_q.delete();
        exp_data_q.delete();
        checks++;
        if (obs_addr_q.size() != rd_idx) begin
            errors++;
            $display("[TB] FAIL basic_write_count got %0d want %0d", obs_addr_q.size(), rd_idx);
        end
        rd_idx = obs_addr_q.size();
        checks++;
        if ({done, cpu_reset, error, in_ready} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL basic_status got done/cpurst/err/ready=%b want 1000",
                     {done, cpu_reset, error, in_ready});
        end
        checks++;
        if (words_loaded !== 16'd2) begin
            errors++;
            $display("[TB] FAIL basic_words got %0d want 2", words_loaded);
        end
    endtask

    task automatic test_start_rearm();
        pulse_start();
        checks++;
        if ({cpu_reset, done, in_ready} !== 3'b101 || words_loaded !== '0) begin
            errors++;
            $display("[TB] FAIL rearm got cpurst/done/ready=%b words=%0d want 101 words=0",
                     {cpu_reset, done, in_ready}, words_loaded);
        end
    endtask

    task automatic test_bad_checksum();
        words_q = '{16'h0010, 16'hFC10};
        build_frame(1'b1, 8'h3F);
        send_frame(0, -1);
        foreach (exp_addr_q[i]) begin
            checks++;
            if (rd_idx >= obs_addr_q.size()) begin
                errors++;
                $display("[TB] FAIL badcsum_write%0d got none want addr=%0d", i, exp_addr_q[i]);
            end else if (obs_addr_q[rd_idx] !== exp_addr_q[i] || obs_data_q[rd_idx] !== exp_data_q[i]) begin
                errors++;
                $display("[TB] FAIL badcsum_write%0d got %0d:%h want %0d:%h", i,
                         obs_addr_q[rd_idx], obs_data_q[rd_idx], exp_addr_q[i], exp_data_q[i]);
            end
            rd_idx++;
        end
        exp_addr_q.delete();
        exp_data_q.delete();
        checks++;
        if ({error, cpu_reset, done, in_ready} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL badcsum_status got err/cpurst/done/ready=%b want 1100",
                     {error, cpu_reset, done, in_ready});
        end
        // Bytes offered while not ready must be ignored.
        in_data  = 8'hAA;
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (error !== 1'b1 || words_loaded !== 16'd2 || obs_addr_q.size() != rd_idx) begin
            errors++;
            $display("[TB] FAIL badcsum_hold got err=%b words=%0d writes=%0d want 1/2/%0d",
                     error, words_loaded, obs_addr_q.size(), rd_idx);
        end
        rd_idx = obs_addr_q.size();
        pulse_start();
        checks++;
        if (error !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL badcsum_rearm got err=%b ready=%b want 0/1", error, in_ready);
        end
    endtask

    task automatic test_zero_length();
        words_q.delete();
        build_frame(1'b0, 8'h00);
        send_frame(0, -1);
        idle(2);
        checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0 || obs_addr_q.size() != rd_idx) begin
            errors++;
            $display("[TB] FAIL zero_len got done=%b cpurst=%b writes=%0d want 1/0/0",
                     done, cpu_reset, obs_addr_q.size() - rd_idx);
        end
        rd_idx = obs_addr_q.size();
        pulse_start();
    endtask

    task automatic test_overflow();
        send_byte(8'h80);
        send_byte(8'h01);
        checks++;
        if (error !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overflow_err got err=%b ready=%b want 1/0", error, in_ready);
        end
        idle(3);
        checks++;
        if (obs_addr_q.size() != rd_idx || cpu_reset !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_nowrite got writes=%0d cpurst=%b want 0/1",
                     obs_addr_q.size() - rd_idx, cpu_reset);
        end
        rd_idx = obs_addr_q.size();
        pulse_start();
    endtask

    // 100-word frame with random valid gaps and a start pulse that must be ignored.
    task automatic test_gaps();
        words_q.delete();
        for (int i = 0; i < 100; i++) words_q.push_back(16'($urandom));
        build_frame(1'b0, 8'h00);
        send_frame(5, 40);
        foreach (exp_addr_q[i]) begin
            checks++;
            if (rd_idx >= obs_addr_q.size()) begin
                errors++;
                $display("[TB] FAIL gaps_write%0d got none want addr=%0d", i, exp_addr_q[i]);
            end else if (obs_addr_q[rd_idx] !== exp_addr_q[i] || obs_data_q[rd_idx] !== exp_data_q[i]) begin
                errors++;
                $display("[TB] FAIL gaps_write%0d got %0d:%h want %0d:%h", i,
                         obs_addr_q[rd_idx], obs_data_q[rd_idx], exp_addr_q[i], exp_data_q[i]);
            end
            rd_idx++;
        end
        exp_addr_q.delete();
        exp_data_q.delete();
        checks++;
        if (obs_addr_q.size() != rd_idx || done !== 1'b1 || words_loaded !== 16'd100) begin
            errors++;
            $display("[TB] FAIL gaps_end got writes_extra=%0d done=%b words=%0d want 0/1/100",
                     obs_addr_q.size() - rd_idx, done, words_loaded);
        end
        rd_idx = obs_addr_q.size();
        pulse_start();
    endtask

    task automatic test_reset_midload();
        words_q.delete();
        for (int i = 0; i < 10; i++) words_q.push_back(16'($urandom));
        build_frame(1'b0, 8'h00);
        for (int i = 0; i < 8; i++) send_byte(frame_q[i]);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_idx >= obs_addr_q.size()) begin
                errors++;
                $display("[TB] FAIL midload_write%0d got none want addr=%0d", i, exp_addr_q[i]);
            end else if (obs_addr_q[rd_idx] !== exp_addr_q[i] || obs_data_q[rd_idx] !== exp_data_q[i]) begin
                errors++;
                $display("[TB] FAIL midload_write%0d got %0d:%h want %0d:%h", i,
                         obs_addr_q[rd_idx], obs_data_q[rd_idx], exp_addr_q[i], exp_data_q[i]);
            end
            rd_idx++;
        end
        exp_addr_q.delete();
        exp_data_q.delete();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        checks++;
        if (words_loaded !== '0 || in_ready !== 1'b1 || rom_addr !== '0 || cpu_reset !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midload_reset got words=%0d ready=%b addr=%0d cpurst=%b want 0/1/0/1",
                     words_loaded, in_ready, rom_addr, cpu_reset);
        end
        words_q = '{16'h1234, 16'hABCD};
        build_frame(1'b0, 8'h00);
        send_frame(0, -1);
        foreach (exp_addr_q[i]) begin
            checks++;
            if (rd_idx >= obs_addr_q.size()) begin
                errors++;
                $display("[TB] FAIL reload_write%0d got none want addr=%0d", i, exp_addr_q[i]);
            end else if (obs_addr_q[rd_idx] !== exp_addr_q[i] || obs_data_q[rd_idx] !== exp_data_q[i]) begin
                errors++;
                $display("[TB] FAIL reload_write%0d got %0d:%h want %0d:%h", i,
                         obs_addr_q[rd_idx], obs_data_q[rd_idx], exp_addr_q[i], exp_data_q[i]);
            end
            rd_idx++;
        end
        exp_addr_q.delete();
        exp_data_q.delete();
        checks++;
        if (obs_addr_q.size() != rd_idx || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reload_end got writes_extra=%0d done=%b want 0/1",
                     obs_addr_q.size() - rd_idx, done);
        end
        rd_idx = obs_addr_q.size();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_start_rearm();
        test_bad_checksum();
        test_zero_length();
        test_overflow();
        test_gaps();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
